// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core and a debug master.
// An in-order tag FIFO routes read data and load metadata back to the owning requester.
//
// Ports:
//   clock, reset (sync, active-low)
//   req0_*/req1_*  : request channels (valid/ready, write, address, data, byte_en, load format)
//   mem_*          : shared memory command port and in-order read-data return
//   rsp0/1_valid   : returning data owner strobes
//   rsp_data, rsp_address, rsp_log2_bytes, rsp_unsigned : feed to memory_receive
//   outstanding    : reads in flight
//   error          : sticky, read data arrived with nothing outstanding
module dmem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 32,
    parameter int NUM_BYTES      = DATA_WIDTH / 8,
    parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES),
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic                         req0_write,
    input  logic [ADDRESS_BITS-1:0]      req0_address,
    input  logic [DATA_WIDTH-1:0]        req0_data,
    input  logic [NUM_BYTES-1:0]         req0_byte_en,
    input  logic [LOG2_NUM_BYTES-1:0]    req0_log2_bytes,
    input  logic                         req0_unsigned,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic                         req1_write,
    input  logic [ADDRESS_BITS-1:0]      req1_address,
    input  logic [DATA_WIDTH-1:0]        req1_data,
    input  logic [NUM_BYTES-1:0]         req1_byte_en,
    input  logic [LOG2_NUM_BYTES-1:0]    req1_log2_bytes,
    input  logic                         req1_unsigned,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [ADDRESS_BITS-1:0]      mem_address,
    output logic [DATA_WIDTH-1:0]        mem_data_out,
    output logic [NUM_BYTES-1:0]         mem_byte_en,
    input  logic                         mem_ready,
    input  logic                         mem_valid,
    input  logic [DATA_WIDTH-1:0]        mem_data_in,
    output logic                         rsp0_valid,
    output logic                         rsp1_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic [ADDRESS_BITS-1:0]      rsp_address,
    output logic [LOG2_NUM_BYTES-1:0]    rsp_log2_bytes,
    output logic                         rsp_unsigned,
    output logic [$clog2(FIFO_DEPTH):0]  outstanding,
    output logic                         error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          error_q, error_d;
    logic          last_q, last_d;

    logic                      fid_q   [FIFO_DEPTH];
    logic [ADDRESS_BITS-1:0]   faddr_q [FIFO_DEPTH];
    logic [LOG2_NUM_BYTES-1:0] flb_q   [FIFO_DEPTH];
    logic                      funs_q  [FIFO_DEPTH];

    logic full, empty;
    logic elig0, elig1;
    logic gnt0, gnt1;
    logic push, pop;

    // Full uses the registered count only, so a same-cycle pop never frees a slot.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign elig0 = req0_valid & (req0_write | ~full);
    assign elig1 = req1_valid & (req1_write | ~full);

    // On a tie the requester that did not win last time is granted.
    // Everything is gated by reset so outputs are 0 while reset is held.
    assign gnt0 = reset & elig0 & (~elig1 | last_q);
    assign gnt1 = reset & elig1 & (~elig0 | ~last_q);

    assign req0_ready = gnt0 & mem_ready;
    assign req1_ready = gnt1 & mem_ready;

    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_data_out = '0;
        mem_byte_en  = '0;
        if (gnt0) begin
            mem_read     = ~req0_write;
            mem_write    = req0_write;
            mem_address  = req0_address;
            mem_data_out = req0_data;
            mem_byte_en  = req0_byte_en;
        end else if (gnt1) begin
            mem_read     = ~req1_write;
            mem_write    = req1_write;
            mem_address  = req1_address;
            mem_data_out = req1_data;
            mem_byte_en  = req1_byte_en;
        end
    end

    assign push = (req0_ready | req1_ready) & mem_read;
    assign pop  = reset & mem_valid & ~empty;

    always_comb begin
        rsp0_valid     = 1'b0;
        rsp1_valid     = 1'b0;
        rsp_address    = '0;
        rsp_log2_bytes = '0;
        rsp_unsigned   = 1'b0;
        if (pop) begin
            rsp0_valid     = ~fid_q[rd_ptr_q];
            rsp1_valid     = fid_q[rd_ptr_q];
            rsp_address    = faddr_q[rd_ptr_q];
            rsp_log2_bytes = flb_q[rd_ptr_q];
            rsp_unsigned   = funs_q[rd_ptr_q];
        end
    end

    assign rsp_data    = reset ? mem_data_in : '0;
    assign outstanding = reset ? count_q : '0;
    assign error       = reset & error_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        last_d = last_q;
        if (req0_ready) begin
            last_d = 1'b0;
        end else if (req1_ready) begin
            last_d = 1'b1;
        end
        error_d = error_q | (mem_valid & empty);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
            last_q   <= last_d;
        end
    end

    // Tag storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            fid_q[wr_ptr_q]   <= req1_ready;
            faddr_q[wr_ptr_q] <= mem_address;
            flb_q[wr_ptr_q]   <= req1_ready ? req1_log2_bytes : req0_log2_bytes;
            funs_q[wr_ptr_q]  <= req1_ready ? req1_unsigned : req0_unsigned;
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between two requesters, requester 0 (core load/store stage) and requester 1 (debug/scan master), using round-robin arbitration. Every issued read is recorded in an in-order tag FIFO holding its owner, address and load format. When read data returns, the block routes it to the owning requester and supplies the matching address, `log2_bytes` and `unsigned_load` to the downstream `memory_receive` alignment/sign-extension stage.

## Interface
Parameters:
- DATA_WIDTH, 32: memory data width.
- ADDRESS_BITS, 32: address width.
- NUM_BYTES, DATA_WIDTH/8: bytes per word.
- LOG2_NUM_BYTES, log2(NUM_BYTES): width of the load-size field.
- FIFO_DEPTH, 4: maximum outstanding reads; must be a power of two, ≥2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- reqN_valid  in  1  requester N (N = 0, 1) has a request.
- reqN_ready  out  1  request N accepted this cycle.
- reqN_write  in  1  1 = store, 0 = load.
- reqN_address  in  ADDRESS_BITS  byte address.
- reqN_data  in  DATA_WIDTH  store data.
- reqN_byte_en  in  NUM_BYTES  store byte enables.
- reqN_log2_bytes  in  LOG2_NUM_BYTES  load size.
- reqN_unsigned  in  1  zero-extend the load.
- mem_read, mem_write  out  1  memory command strobes.
- mem_address  out  ADDRESS_BITS; mem_data_out  out  DATA_WIDTH; mem_byte_en  out  NUM_BYTES.
- mem_ready  in  1  memory accepts the command this cycle.
- mem_valid  in  1  read data is valid; responses return in issue order.
- mem_data_in  in  DATA_WIDTH  read data.
- rsp0_valid, rsp1_valid  out  1  returning data belongs to requester 0 / 1.
- rsp_data  out  DATA_WIDTH  mem_data_in passthrough.
- rsp_address  out  ADDRESS_BITS; rsp_log2_bytes  out  LOG2_NUM_BYTES; rsp_unsigned  out  1  drive memory_receive.
- outstanding  out  log2(FIFO_DEPTH)+1  reads in flight.
- error  out  1  sticky: mem_valid arrived while no read was outstanding.

## Operation
- Eligibility: a request is eligible when reqN_valid=1, and either reqN_write=1 or the FIFO is not full.
- Full check: uses the registered count only. A pop in the same cycle does not free a slot for issue.
- Grant: combinational round-robin over eligible requesters. The requester not granted last wins a tie. last_grant resets to 1, so requester 0 wins the first tie.
- Issue:
  - Granted request drives mem_read = ~write and mem_write = write, plus address, data and byte_en.
  - Idle cycle: all mem_* outputs are 0.
  - reqN_ready = grant_N & mem_ready. The handshake fires when valid & ready.
- Fire effects:
  - last_grant updates to the requester that fired.
  - A read pushes {id, address, log2_bytes, unsigned} into the FIFO.
  - A write has no response and no FIFO entry.
- Response: with mem_valid=1 and FIFO non-empty:
  - rsp<head id>_valid=1.
  - rsp_address, rsp_log2_bytes and rsp_unsigned come from the head entry; rsp_data = mem_data_in.
  - The head pops at the clock edge.
- Spurious response: mem_valid=1 with the FIFO empty produces no rsp*_valid and sets error. error clears only on reset.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- When no response is active, rsp_* metadata outputs are 0.
- reqN_* inputs are sampled only in the fire cycle. A requester may change a request that has not yet fired.

## Timing
- Issue latency: 0 cycles. Request to mem_* is combinational, and the state update happens at the edge where the request fires.
- Response latency: 0 cycles. mem_valid to rsp*_valid is combinational, so memory_receive sees metadata aligned with its data.
- Throughput: one command per cycle. Up to FIFO_DEPTH reads may be outstanding.
- Reset (reset=0 at a rising edge):
  - FIFO is flushed, outstanding=0, error=0, last_grant=1.
  - All outputs go to 0 in the same cycle reset is asserted, regardless of inputs.
  - Reset mid-operation abandons reads in flight. The memory must not return them afterwards; if it does, error is set.

## Test plan
- Reset: hold reset=0 for 2 cycles with both reqN_valid=1 -> every output 0, outstanding=0, error=0.
- Single load:
  - Stimulus: req0 reads address 32'h2 with log2_bytes=1, unsigned=0, mem_ready=1; two cycles later mem_valid=1 with data 32'hFFFF0000.
  - Required: rsp0_valid=1, rsp1_valid=0, rsp_address=32'h2, rsp_log2_bytes=1, rsp_unsigned=0, rsp_data=32'hFFFF0000, and outstanding goes 0→1→0.
- Fairness: both requesters issue loads continuously with mem_ready=1 and no responses -> grants go 0,1,0,1. After 4 cycles outstanding=4 and both reqN_ready=0.
- Full FIFO:
  - Stimulus: with 4 reads outstanding, req1 issues a write to 32'h8 with byte_en 4'hF.
  - Required: req1_ready=1 and mem_write=1.
  - Then a load arriving in the same cycle as a mem_valid response stalls for one cycle and issues the next cycle.
- Routing:
  - Stimulus: req0 loads 32'h4 (log2_bytes=2), then req1 loads 32'h1 (log2_bytes=0, unsigned=1); responses return 32'hAAAAAAAA and 32'h000000FF.
  - Required: rsp0_valid comes first with rsp_address=32'h4, then rsp1_valid with rsp_address=32'h1 and rsp_unsigned=1.
- Error and reset:
  - A mem_valid pulse with an empty FIFO -> error=1, no rsp*_valid, and error stays 1.
  - Reset with 3 loads outstanding -> outstanding=0, error=0 on the next cycle.
